pll_lock_rst_seq: RTL

//  Consumer end of the SDRAM PLL lock interface. Synchronises the asynchronous PLL lock flag into the
//  PLL output clock domain. Holds the downstream logic in reset until lock has been stable long enough,

---
 rtl/pll_lock_rst_seq_if.sv | 23 ++
 rtl/pll_lock_rst_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pll_lock_rst_seq_if.sv
// PLL lock / reset sequencing bundle between the PLL, the sequencer and the SDRAM controller.
// master: the sequencer (consumes lock, drives reset/init/status).
// slave : the environment (drives lock, observes reset/init/status).
interface pll_lock_rst_seq_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             sys_rst_n;
    logic             sdram_init;
    logic             ready;
    logic             lock_lost;
    logic [CNT_W-1:0] relock_cnt;

    modport master (
        input  pll_locked,
        output sys_rst_n, sdram_init, ready, lock_lost, relock_cnt
    );

    modport slave (
        output pll_locked,
        input  sys_rst_n, sdram_init, ready, lock_lost, relock_cnt
    );
endinterface

// File: rtl/pll_lock_rst_seq.sv
// PLL lock reset sequencer: synchronises the raw lock flag, holds downstream reset until lock is
// stable, waits out the SDRAM power-up time, then pulses SDRAM init and reports ready.
// Optional feature macro: PLL_SEQ_RELOCK_CNT_EN (defined -> saturating relock counter,
// undefined -> relock_cnt tied to 0).
module pll_lock_rst_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int PWRUP_CYC       = 28572,
    parameter int CNT_W           = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    pll_lock_rst_seq_if.master bus
);
    localparam int MAX_CYC = (LOCK_STABLE_CYC > PWRUP_CYC) ? LOCK_STABLE_CYC : PWRUP_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] PWRUP_LAST  = CW'(PWRUP_CYC - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, PWRUP_WAIT, RUN} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   init_q, init_d;
    logic                   ready_q, ready_d;
    logic                   lost_q, lost_d;
    logic                   loss;

    // Lock flag synchroniser; the oldest stage is the only one used by the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // State, shared counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            sys_rst_q <= 1'b0;
            init_q    <= 1'b0;
            ready_q   <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sys_rst_q <= sys_rst_d;
            init_q    <= init_d;
            ready_q   <= ready_d;
            lost_q    <= lost_d;
        end
    end

    // Next state; loss of lock in PWRUP_WAIT/RUN overrides any terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = 1'b0;
        loss    = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = PWRUP_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            PWRUP_WAIT: begin
                if (!lock_s) begin
                    loss    = 1'b1;
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == PWRUP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    init_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    loss    = 1'b1;
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        sys_rst_d = (state_d == PWRUP_WAIT) || (state_d == RUN);
        ready_d   = (state_d == RUN);
        lost_d    = lost_q | (loss && (state_q == RUN));
    end

    assign bus.sys_rst_n  = sys_rst_q;
    assign bus.sdram_init = init_q;
    assign bus.ready      = ready_q;
    assign bus.lock_lost  = lost_q;

`ifdef PLL_SEQ_RELOCK_CNT_EN
    logic [CNT_W-1:0] relock_q;

    // Saturating count of lock losses after reset had been released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        relock_q <= '0;
        else if (loss && (relock_q != '1)) relock_q <= relock_q + CNT_W'(1);
    end

    assign bus.relock_cnt = relock_q;
`else
    assign bus.relock_cnt = '0;
`endif
endmodule
